// File: rtl/vscale_hasti_arbiter_if.sv
// HASTI (AHB-Lite) signal bundle; the arbiter takes two of these on its master-facing
// side (slave modport) and drives one toward the SRAM (master modport).
interface vscale_hasti_arbiter_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/vscale_hasti_arbiter.sv
// Two-master to one-slave HASTI arbiter: a losing or stalled address phase is parked in a
// per-master holding register and the master is held off with hready until it completes.
module vscale_hasti_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    vscale_hasti_arbiter_if.slave  m0,
    vscale_hasti_arbiter_if.slave  m1,
    vscale_hasti_arbiter_if.master s
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic        lock;
    } req_t;

    owner_e r_owner, w_owner_nxt;
    logic   r_last_grant, w_last_grant_nxt;
    logic   r_pend0, r_pend1, w_pend0_nxt, w_pend1_nxt;
    req_t   r_req0, r_req1, r_hold;
    req_t   w_bus0, w_bus1, w_src0, w_src1, w_sreq;
    logic   w_hready0, w_hready1;
    logic   w_live0, w_live1;
    logic   w_cand0, w_cand1;
    logic   w_issue, w_grant1;
    logic   w_unused;

    assign w_bus0 = '{addr: m0.haddr, wr: m0.hwrite, size: m0.hsize, prot: m0.hprot, lock: m0.hmastlock};
    assign w_bus1 = '{addr: m1.haddr, wr: m1.hwrite, size: m1.hsize, prot: m1.hprot, lock: m1.hmastlock};

    assign w_hready0 = r_pend0 ? 1'b0 : ((r_owner == OWN_M0) ? s.hready : 1'b1);
    assign w_hready1 = r_pend1 ? 1'b0 : ((r_owner == OWN_M1) ? s.hready : 1'b1);

    assign w_live0 = hresetn & m0.htrans[1] & w_hready0;
    assign w_live1 = hresetn & m1.htrans[1] & w_hready1;
    assign w_cand0 = r_pend0 | w_live0;
    assign w_cand1 = r_pend1 | w_live1;
    assign w_src0  = r_pend0 ? r_req0 : w_bus0;
    assign w_src1  = r_pend1 ? r_req1 : w_bus1;
    assign w_issue = s.hready & (w_cand0 | w_cand1);

    always_comb begin
        w_grant1 = w_cand1;
        if (w_cand0 && w_cand1) begin
            w_grant1 = ROUND_ROBIN ? ~r_last_grant : 1'b0;
        end
    end

    // Address/control stay parked on the last issued values whenever nothing new goes out.
    assign w_sreq = w_issue ? (w_grant1 ? w_src1 : w_src0) : r_hold;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_owner      <= OWN_NONE;
            r_last_grant <= 1'b1;
            r_pend0      <= 1'b0;
            r_pend1      <= 1'b0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_pend0      <= w_pend0_nxt;
            r_pend1      <= w_pend1_nxt;
        end
    end

    // Payload registers carry no reset: they are only consumed behind a set pend flag.
    always_ff @(posedge hclk) begin
        if (w_live0) r_req0 <= w_bus0;
        if (w_live1) r_req1 <= w_bus1;
        r_hold <= w_sreq;
    end

    always_comb begin
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_pend0_nxt      = w_cand0 & ~(w_issue & ~w_grant1);
        w_pend1_nxt      = w_cand1 & ~(w_issue & w_grant1);
        if (s.hready) begin
            if (!w_issue)      w_owner_nxt = OWN_NONE;
            else if (w_grant1) w_owner_nxt = OWN_M1;
            else               w_owner_nxt = OWN_M0;
        end
        if (w_issue) begin
            w_last_grant_nxt = w_grant1;
        end
    end

    // Wait cycles present IDLE so the slave never sees the already-accepted transfer twice.
    always_comb begin
        s.haddr     = w_sreq.addr;
        s.hwrite    = w_sreq.wr;
        s.hsize     = w_sreq.size;
        s.hprot     = w_sreq.prot;
        s.hmastlock = w_sreq.lock;
        s.hburst    = HBURST_SINGLE;
        s.htrans    = w_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
        s.hwdata    = (r_owner == OWN_M1) ? m1.hwdata : m0.hwdata;
        m0.hready   = w_hready0;
        m1.hready   = w_hready1;
        m0.hresp    = (r_owner == OWN_M0 && !r_pend0) ? s.hresp : 1'b0;
        m1.hresp    = (r_owner == OWN_M1 && !r_pend1) ? s.hresp : 1'b0;
        m0.hrdata   = s.hrdata;
        m1.hrdata   = s.hrdata;
    end

    // Burst type and SEQ vs NONSEQ are dropped: every issued beat is a SINGLE NONSEQ.
    assign w_unused = ^{m0.hburst, m1.hburst, m0.htrans[0], m1.htrans[0]};

endmodule
